// File: rtl/ddr_timing_monitor.sv
// DDR command-stream timing checker: tracks per-bank and rank-wide elapsed-cycle
// history and open/idle bank state, and reports timing and protocol violations.
package ddr_timing_monitor_pkg;

  typedef enum logic [3:0] {
    CMD_MRS  = 4'b0000,
    CMD_REF  = 4'b0001,
    CMD_PRE  = 4'b0010,
    CMD_ACT  = 4'b0011,
    CMD_WR   = 4'b0100,
    CMD_RD   = 4'b0101,
    CMD_NOP  = 4'b0111,
    CMD_DES  = 4'b1000,
    CMD_PREA = 4'b1010
  } cmd_e;

  localparam int VIOL_TFAW = 0;
  localparam int VIOL_TRCD = 1;
  localparam int VIOL_TRP  = 2;
  localparam int VIOL_TRAS = 3;
  localparam int VIOL_TRRD = 4;
  localparam int VIOL_TWR  = 5;
  localparam int VIOL_TRTP = 6;
  localparam int VIOL_TWTR = 7;
  localparam int VIOL_PROT = 15;

endpackage

module ddr_timing_monitor
  import ddr_timing_monitor_pkg::*;
#(
  parameter int NUM_BANKS = 8,
  parameter int BANK_W    = 3,
  parameter int CNT_W     = 8,
  parameter int T_RCD     = 18,
  parameter int T_RP      = 18,
  parameter int T_RAS     = 42,
  parameter int T_RRD     = 8,
  parameter int T_WR      = 15,
  parameter int T_WTR     = 8,
  parameter int T_RTP     = 8,
  parameter int T_FAW     = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [3:0]           cmd,
  input  logic [BANK_W-1:0]    cmd_bank,
  input  logic                 clear,
  output logic                 viol_valid,
  output logic [3:0]           viol_type,
  output logic [15:0]          viol_mask,
  output logic [BANK_W-1:0]    viol_bank,
  output logic [15:0]          viol_count,
  output logic [NUM_BANKS-1:0] bank_open
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] T_RCD_C = CNT_W'(T_RCD);
  localparam logic [CNT_W-1:0] T_RP_C  = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] T_RAS_C = CNT_W'(T_RAS);
  localparam logic [CNT_W-1:0] T_RRD_C = CNT_W'(T_RRD);
  localparam logic [CNT_W-1:0] T_WR_C  = CNT_W'(T_WR);
  localparam logic [CNT_W-1:0] T_WTR_C = CNT_W'(T_WTR);
  localparam logic [CNT_W-1:0] T_RTP_C = CNT_W'(T_RTP);
  localparam logic [CNT_W-1:0] T_FAW_C = CNT_W'(T_FAW);

  // Elapsed-cycle history; each counter holds t_now - t_event, saturating.
  logic [NUM_BANKS-1:0][CNT_W-1:0] act_cnt_q, act_cnt_d;
  logic [NUM_BANKS-1:0][CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [NUM_BANKS-1:0][CNT_W-1:0] rd_cnt_q,  rd_cnt_d;
  logic [NUM_BANKS-1:0][CNT_W-1:0] wr_cnt_q,  wr_cnt_d;
  logic [CNT_W-1:0]                any_act_cnt_q, any_act_cnt_d;
  logic [CNT_W-1:0]                any_wr_cnt_q,  any_wr_cnt_d;
  logic [3:0][CNT_W-1:0]           faw_q, faw_d;

  logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
  logic                 viol_valid_q, viol_valid_d;
  logic [3:0]           viol_type_q,  viol_type_d;
  logic [15:0]          viol_mask_q,  viol_mask_d;
  logic [BANK_W-1:0]    viol_bank_q,  viol_bank_d;
  logic [15:0]          viol_count_q, viol_count_d;

  logic [NUM_BANKS-1:0] bank_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    for (int b = 0; b < NUM_BANKS; b++) begin
      act_cnt_d[b] = sat_inc(act_cnt_q[b]);
      pre_cnt_d[b] = sat_inc(pre_cnt_q[b]);
      rd_cnt_d[b]  = sat_inc(rd_cnt_q[b]);
      wr_cnt_d[b]  = sat_inc(wr_cnt_q[b]);
    end
    any_act_cnt_d = sat_inc(any_act_cnt_q);
    any_wr_cnt_d  = sat_inc(any_wr_cnt_q);
    for (int i = 0; i < 4; i++) faw_d[i] = sat_inc(faw_q[i]);
    bank_open_d = bank_open_q;
    viol_mask_d = '0;
    viol_bank_d = '0;
    bank_bad    = '0;

    if (cmd_valid) begin
      case (cmd)
        CMD_ACT: begin
          if (bank_open_q[cmd_bank])              viol_mask_d[VIOL_PROT] = 1'b1;
          if (pre_cnt_q[cmd_bank] < T_RP_C)       viol_mask_d[VIOL_TRP]  = 1'b1;
          if (any_act_cnt_q < T_RRD_C)            viol_mask_d[VIOL_TRRD] = 1'b1;
          if (faw_q[3] < T_FAW_C)                 viol_mask_d[VIOL_TFAW] = 1'b1;
          act_cnt_d[cmd_bank]   = CNT_ONE;
          any_act_cnt_d         = CNT_ONE;
          faw_d                 = {sat_inc(faw_q[2]), sat_inc(faw_q[1]),
                                   sat_inc(faw_q[0]), CNT_ONE};
          bank_open_d[cmd_bank] = 1'b1;
          viol_bank_d           = cmd_bank;
        end
        CMD_RD: begin
          if (!bank_open_q[cmd_bank])             viol_mask_d[VIOL_PROT] = 1'b1;
          if (act_cnt_q[cmd_bank] < T_RCD_C)      viol_mask_d[VIOL_TRCD] = 1'b1;
          if (any_wr_cnt_q < T_WTR_C)             viol_mask_d[VIOL_TWTR] = 1'b1;
          rd_cnt_d[cmd_bank] = CNT_ONE;
          viol_bank_d        = cmd_bank;
        end
        CMD_WR: begin
          if (!bank_open_q[cmd_bank])             viol_mask_d[VIOL_PROT] = 1'b1;
          if (act_cnt_q[cmd_bank] < T_RCD_C)      viol_mask_d[VIOL_TRCD] = 1'b1;
          wr_cnt_d[cmd_bank] = CNT_ONE;
          any_wr_cnt_d       = CNT_ONE;
          viol_bank_d        = cmd_bank;
        end
        CMD_PRE: begin
          if (bank_open_q[cmd_bank]) begin
            if (act_cnt_q[cmd_bank] < T_RAS_C)    viol_mask_d[VIOL_TRAS] = 1'b1;
            if (rd_cnt_q[cmd_bank] < T_RTP_C)     viol_mask_d[VIOL_TRTP] = 1'b1;
            if (wr_cnt_q[cmd_bank] < T_WR_C)      viol_mask_d[VIOL_TWR]  = 1'b1;
          end
          pre_cnt_d[cmd_bank]   = CNT_ONE;
          bank_open_d[cmd_bank] = 1'b0;
          viol_bank_d           = cmd_bank;
        end
        CMD_PREA: begin
          for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_open_q[b]) begin
              if (act_cnt_q[b] < T_RAS_C) begin
                viol_mask_d[VIOL_TRAS] = 1'b1;
                bank_bad[b]            = 1'b1;
              end
              if (rd_cnt_q[b] < T_RTP_C) begin
                viol_mask_d[VIOL_TRTP] = 1'b1;
                bank_bad[b]            = 1'b1;
              end
              if (wr_cnt_q[b] < T_WR_C) begin
                viol_mask_d[VIOL_TWR]  = 1'b1;
                bank_bad[b]            = 1'b1;
              end
            end
            pre_cnt_d[b] = CNT_ONE;
          end
          bank_open_d = '0;
        end
        CMD_REF: begin
          for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_open_q[b]) begin
              viol_mask_d[VIOL_PROT] = 1'b1;
              bank_bad[b]            = 1'b1;
            end
            if (pre_cnt_q[b] < T_RP_C) begin
              viol_mask_d[VIOL_TRP]  = 1'b1;
              bank_bad[b]            = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    // Rank-wide commands report the lowest offending bank.
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (bank_bad[b]) viol_bank_d = BANK_W'(b);
    end

    viol_valid_d = |viol_mask_d;
    viol_type_d  = '0;
    for (int k = 15; k >= 0; k--) begin
      if (viol_mask_d[k]) viol_type_d = 4'(k);
    end

    if (clear)
      viol_count_d = '0;
    else if (viol_valid_d && !(&viol_count_q))
      viol_count_d = viol_count_q + 16'd1;
    else
      viol_count_d = viol_count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: history counters reset to saturation (not zero) so that the first
      // commands after reset see no stale timing and raise no false violations.
      act_cnt_q     <= '1;
      pre_cnt_q     <= '1;
      rd_cnt_q      <= '1;
      wr_cnt_q      <= '1;
      any_act_cnt_q <= '1;
      any_wr_cnt_q  <= '1;
      faw_q         <= '1;
      bank_open_q   <= '0;
      viol_valid_q  <= 1'b0;
      viol_type_q   <= '0;
      viol_mask_q   <= '0;
      viol_bank_q   <= '0;
      viol_count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      act_cnt_q     <= act_cnt_d;
      pre_cnt_q     <= pre_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      any_act_cnt_q <= any_act_cnt_d;
      any_wr_cnt_q  <= any_wr_cnt_d;
      faw_q         <= faw_d;
      bank_open_q   <= bank_open_d;
      viol_valid_q  <= viol_valid_d;
      viol_type_q   <= viol_type_d;
      viol_mask_q   <= viol_mask_d;
      viol_bank_q   <= viol_bank_d;
      viol_count_q  <= viol_count_d;
    end
  end

  assign viol_valid = viol_valid_q;
  assign viol_type  = viol_type_q;
  assign viol_mask  = viol_mask_q;
  assign viol_bank  = viol_bank_q;
  assign viol_count = viol_count_q;
  assign bank_open  = bank_open_q;

endmodule

// File: tb/tb_ddr_timing_monitor.sv
// Directed bench for ddr_timing_monitor: each step drives one cycle of command
// bus activity and checks the registered result one cycle later.
module tb_ddr_timing_monitor;
  import ddr_timing_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd = 4'b0111;
  logic [2:0]  cmd_bank = '0;
  logic        clear = 1'b0;
  logic        viol_valid;
  logic [3:0]  viol_type;
  logic [15:0] viol_mask;
  logic [2:0]  viol_bank;
  logic [15:0] viol_count;
  logic [7:0]  bank_open;

  int checks = 0;
  int failures = 0;

  ddr_timing_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_bank   (cmd_bank),
    .clear      (clear),
    .viol_valid (viol_valid),
    .viol_type  (viol_type),
    .viol_mask  (viol_mask),
    .viol_bank  (viol_bank),
    .viol_count (viol_count),
    .bank_open  (bank_open)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle; on return the outputs reflect this cycle's command.
  task automatic step(input logic v, input logic [3:0] c, input logic [2:0] b);
    @(negedge clk);
    cmd_valid = v;
    cmd       = c;
    cmd_bank  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, CMD_NOP, 3'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step(1'b0, CMD_NOP, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_viol(input string tag, input logic [3:0] t, input logic [15:0] m,
                            input logic [2:0] b, input logic [15:0] cnt);
    check({tag, ".valid"}, {31'd0, viol_valid}, 32'd1);
    check({tag, ".type"},  {28'd0, viol_type},  {28'd0, t});
    check({tag, ".mask"},  {16'd0, viol_mask},  {16'd0, m});
    check({tag, ".bank"},  {29'd0, viol_bank},  {29'd0, b});
    check({tag, ".count"}, {16'd0, viol_count}, {16'd0, cnt});
  endtask

  task automatic check_quiet(input string tag, input logic [15:0] cnt);
    check({tag, ".valid"}, {31'd0, viol_valid}, 32'd0);
    check({tag, ".count"}, {16'd0, viol_count}, {16'd0, cnt});
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    step(1'b0, CMD_NOP, 3'd0);
    step(1'b1, CMD_ACT, 3'd2);
    check("rst.valid", {31'd0, viol_valid}, 32'd0);
    check("rst.type",  {28'd0, viol_type},  32'd0);
    check("rst.mask",  {16'd0, viol_mask},  32'd0);
    check("rst.bank",  {29'd0, viol_bank},  32'd0);
    check("rst.count", {16'd0, viol_count}, 32'd0);
    check("rst.open",  {24'd0, bank_open},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read to idle bank right after reset
    step(1'b1, CMD_RD, 3'd3);
    check_viol("rd_idle", 4'hF, 16'h8000, 3'd3, 16'd1);

    // Read before tRCD, then at tRCD, then tWTR
    do_reset();
    step(1'b1, CMD_ACT, 3'd0);
    check_quiet("act_b0", 16'd0);
    check("act_b0.open", {24'd0, bank_open}, 32'h01);
    idle(9);
    step(1'b1, CMD_RD, 3'd0);
    check_viol("trcd", 4'd1, 16'h0002, 3'd0, 16'd1);
    idle(7);
    step(1'b1, CMD_RD, 3'd0);
    check_quiet("trcd_ok", 16'd1);
    step(1'b1, CMD_WR, 3'd0);
    check_quiet("wr_ok", 16'd1);
    step(1'b1, CMD_RD, 3'd0);
    check_viol("twtr", 4'd7, 16'h0080, 3'd0, 16'd2);

    // tRRD
    do_reset();
    step(1'b1, CMD_ACT, 3'd0);
    idle(4);
    step(1'b1, CMD_ACT, 3'd1);
    check_viol("trrd", 4'd4, 16'h0010, 3'd1, 16'd1);
    check("trrd.open", {24'd0, bank_open}, 32'h03);

    // tFAW window: ACTs at 0,8,16,24,32,48
    do_reset();
    step(1'b1, CMD_ACT, 3'd0);
    for (int b = 1; b < 4; b++) begin
      idle(7);
      step(1'b1, CMD_ACT, 3'(b));
      check_quiet($sformatf("faw_act%0d", b), 16'd0);
    end
    idle(7);
    step(1'b1, CMD_ACT, 3'd4);
    check_viol("tfaw", 4'd0, 16'h0001, 3'd4, 16'd1);
    idle(15);
    step(1'b1, CMD_ACT, 3'd5);
    check_quiet("tfaw_edge", 16'd1);
    check("tfaw.open", {24'd0, bank_open}, 32'h3F);

    // Early precharge (tRAS + tWR), idle PRE, then tRP
    do_reset();
    step(1'b1, CMD_ACT, 3'd2);
    idle(19);
    step(1'b1, CMD_WR, 3'd2);
    check_quiet("wr_b2", 16'd0);
    idle(9);
    step(1'b1, CMD_PRE, 3'd2);
    check_viol("early_pre", 4'd3, 16'h0028, 3'd2, 16'd1);
    check("early_pre.open", {24'd0, bank_open}, 32'h00);
    step(1'b1, CMD_PRE, 3'd2);
    check_quiet("pre_idle", 16'd1);
    step(1'b1, CMD_ACT, 3'd2);
    check_viol("trp", 4'd2, 16'h0004, 3'd2, 16'd2);

    // REF with open bank, PREA, REF too soon, PREA tRAS
    do_reset();
    step(1'b1, CMD_ACT, 3'd1);
    idle(99);
    step(1'b1, CMD_REF, 3'd6);
    check_viol("ref_open", 4'hF, 16'h8000, 3'd1, 16'd1);
    step(1'b1, CMD_PREA, 3'd0);
    check_quiet("prea_ok", 16'd1);
    check("prea.open", {24'd0, bank_open}, 32'h00);
    step(1'b1, CMD_REF, 3'd0);
    check_viol("ref_trp", 4'd2, 16'h0004, 3'd0, 16'd2);
    idle(20);
    step(1'b1, CMD_ACT, 3'd5);
    idle(7);
    step(1'b1, CMD_ACT, 3'd6);
    check_quiet("act_b6", 16'd2);
    step(1'b1, CMD_PREA, 3'd0);
    check_viol("prea_tras", 4'd3, 16'h0008, 3'd5, 16'd3);

    // Reset mid-operation, command during reset ignored
    do_reset();
    step(1'b1, CMD_ACT, 3'd0);
    @(negedge clk);
    rst_n = 1'b0;
    step(1'b1, CMD_ACT, 3'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst.open", {24'd0, bank_open}, 32'h00);
    step(1'b1, CMD_RD, 3'd0);
    check_viol("mid_rst_rd", 4'hF, 16'h8000, 3'd0, 16'd1);

    // clear coincident with a violation
    @(negedge clk);
    clear = 1'b1;
    step(1'b1, CMD_RD, 3'd0);
    clear = 1'b0;
    check_viol("clear_viol", 4'hF, 16'h8000, 3'd0, 16'd0);
    step(1'b0, CMD_NOP, 3'd0);
    check_quiet("after_clear", 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
